// File: rtl/sap_pkg.sv
// Shared SAP definitions: RAM geometry and the program-loader state encoding.
package sap_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_BYTE = 4'd1,
        ST_WR_SETUP  = 4'd2,
        ST_WR_STROBE = 4'd3,
        ST_WR_HOLD   = 4'd4,
        ST_RD_SETUP  = 4'd5,
        ST_RD_SAMPLE = 4'd6,
        ST_CHECK     = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERROR     = 4'd9
    } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// Additive checksum accumulator (modulo 2**W) with synchronous clear.
// Ports: clk/rst_n, clear (zero the sum), add (sum += din), din, sum (registered).
module loader_checksum #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         add,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum
);

    // clear wins over add; natural W-bit overflow gives the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Program RAM loader: takes a byte stream over valid/ready, writes RAM words
// 0..DEPTH-1 with a setup/strobe/hold write cycle, reads them all back and
// compares additive checksums, then hands the RAM to the CPU via programm_run.
// Ports: clock/reset_n; start; byte_valid/byte_in/byte_ready (stream in);
//        ram_addr/ram_data/ram_we/ram_rd/ram_q (RAM port);
//        programm_run/done/error (session status, sticky until start/reset).
module ram_loader
    import sap_pkg::*;
#(
    parameter int unsigned P_ADDR_W = sap_pkg::ADDR_W,
    parameter int unsigned P_DATA_W = sap_pkg::DATA_W,
    parameter int unsigned P_DEPTH  = sap_pkg::DEPTH
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [P_DATA_W-1:0] byte_in,
    output logic                byte_ready,
    output logic [P_ADDR_W-1:0] ram_addr,
    output logic [P_DATA_W-1:0] ram_data,
    output logic                ram_we,
    output logic                ram_rd,
    input  logic [P_DATA_W-1:0] ram_q,
    output logic                programm_run,
    output logic                done,
    output logic                error
);

    loader_state_e       state_q;
    loader_state_e       state_nxt;
    logic [P_ADDR_W-1:0] addr_q;
    logic [P_DATA_W-1:0] data_q;
    logic [P_DATA_W-1:0] wsum;
    logic [P_DATA_W-1:0] rsum;

    logic last_addr;
    logic start_ok;
    logic accept;
    logic sum_clr;
    logic wsum_add;
    logic rsum_add;
    logic byte_ready_d;
    logic ram_we_d;
    logic ram_rd_d;
    logic run_d;
    logic done_d;
    logic error_d;

    assign last_addr = (addr_q == P_ADDR_W'(P_DEPTH - 1));
    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                 (state_q == ST_ERROR));
    assign accept    = (state_q == ST_WAIT_BYTE) && byte_valid;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_nxt = ST_WAIT_BYTE;
            ST_WAIT_BYTE:               if (byte_valid) state_nxt = ST_WR_SETUP;
            ST_WR_SETUP:                state_nxt = ST_WR_STROBE;
            ST_WR_STROBE:               state_nxt = ST_WR_HOLD;
            ST_WR_HOLD:                 state_nxt = last_addr ? ST_RD_SETUP : ST_WAIT_BYTE;
            ST_RD_SETUP:                state_nxt = ST_RD_SAMPLE;
            ST_RD_SAMPLE:               state_nxt = last_addr ? ST_CHECK : ST_RD_SETUP;
            ST_CHECK:                   state_nxt = (rsum == wsum) ? ST_DONE : ST_ERROR;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Output/control decode; status outputs follow the state being entered so
    // that, once registered, they line up with the state itself.
    always_comb begin
        sum_clr      = start_ok;
        wsum_add     = accept;
        rsum_add     = (state_q == ST_RD_SAMPLE);
        byte_ready_d = (state_nxt == ST_WAIT_BYTE);
        ram_we_d     = (state_nxt == ST_WR_STROBE);
        ram_rd_d     = (state_nxt == ST_RD_SETUP) || (state_nxt == ST_RD_SAMPLE);
        run_d        = (state_nxt == ST_DONE);
        done_d       = (state_nxt == ST_DONE);
        error_d      = (state_nxt == ST_ERROR);
    end

    // Registered outputs; async reset drops ram_we without a clock edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_ready   <= 1'b0;
            ram_we       <= 1'b0;
            ram_rd       <= 1'b0;
            programm_run <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            byte_ready   <= byte_ready_d;
            ram_we       <= ram_we_d;
            ram_rd       <= ram_rd_d;
            programm_run <= run_d;
            done         <= done_d;
            error        <= error_d;
        end
    end

    // Address counter and write-data latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (start_ok) begin
                addr_q <= '0;
            end else if (state_q == ST_WR_HOLD) begin
                addr_q <= last_addr ? '0 : addr_q + P_ADDR_W'(1);
            end else if ((state_q == ST_RD_SAMPLE) && !last_addr) begin
                addr_q <= addr_q + P_ADDR_W'(1);
            end
            if (accept) begin
                data_q <= byte_in;
            end
        end
    end

    assign ram_addr = addr_q;
    assign ram_data = data_q;

    loader_checksum #(.W(P_DATA_W)) u_wsum (
        .clk   (clock),
        .rst_n (reset_n),
        .clear (sum_clr),
        .add   (wsum_add),
        .din   (byte_in),
        .sum   (wsum)
    );

    loader_checksum #(.W(P_DATA_W)) u_rsum (
        .clk   (clock),
        .rst_n (reset_n),
        .clear (sum_clr),
        .add   (rsum_add),
        .din   (ram_q),
        .sum   (rsum)
    );

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: behavioural 16x8 RAM, protocol monitor and a
// session-level reference model (image == bytes sent, pass iff sums agree).
module tb_ram_loader;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       ram_rd;
    logic [7:0] ram_q;
    logic       programm_run;
    logic       done;
    logic       error;

    int n_checks;
    int n_errors;

    logic [7:0] mem [16];
    logic [7:0] sess_bytes [16];
    bit         corrupt_en;
    int         wr_count;
    int         addr_viol;
    int         setup_viol;
    int         hold_viol;
    int         excl_viol;
    logic       prev_we;
    logic [3:0] prev_addr;
    logic [7:0] prev_data;

    ram_loader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_in      (byte_in),
        .byte_ready   (byte_ready),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .programm_run (programm_run),
        .done         (done),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM read port, with an optional fault at address 7
    assign ram_q = ram_rd ? (mem[ram_addr] + ((corrupt_en && ram_addr == 4'd7) ? 8'd1 : 8'd0))
                          : 8'h00;

    // RAM write capture plus protocol monitor
    always @(posedge clock) begin
        if (!reset_n) begin
            prev_we = 1'b0;
        end else begin
            if (ram_we && ram_rd) excl_viol++;
            if (ram_we && programm_run) excl_viol++;
            if (ram_we) begin
                if (!prev_we && (ram_addr != prev_addr || ram_data != prev_data)) setup_viol++;
                if (ram_addr != 4'(wr_count)) addr_viol++;
                mem[ram_addr] = ram_data;
                wr_count++;
            end
            if (!ram_we && prev_we && (ram_addr != prev_addr || ram_data != prev_data)) hold_viol++;
            prev_we   = ram_we;
            prev_addr = ram_addr;
            prev_data = ram_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!byte_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check_val({tag, "_ready_timeout"}, 32'(n), 32'd0);
    endtask

    // Called at a negedge; leaves byte_valid low at a negedge after acceptance
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clock);
        byte_valid = 1'b1;
        byte_in    = b;
        wait_ready("send");
        @(negedge clock);
        byte_valid = 1'b0;
        byte_in    = $urandom_range(255, 0);
    endtask

    task automatic run_session(input string name, input int max_gap, input bit corrupt,
                               input bit poke_wait, input bit poke_read);
        int  n;
        int  ws;
        int  rs;
        bit  exp_pass;
        logic [2:0] exp_flags;

        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        corrupt_en = corrupt;
        wr_count   = 0;
        addr_viol  = 0;
        setup_viol = 0;
        hold_viol  = 0;
        excl_viol  = 0;

        // Reference outcome: sum of bytes written vs sum of bytes the RAM returns
        ws = 0;
        rs = 0;
        for (int i = 0; i < 16; i++) begin
            ws += int'(sess_bytes[i]);
            rs += (int'(sess_bytes[i]) + ((corrupt && i == 7) ? 1 : 0)) % 256;
        end
        exp_pass  = ((ws % 256) == (rs % 256));
        exp_flags = exp_pass ? 3'b101 : 3'b010;

        pulse_start();
        check_val({name, "_start_flags"}, 32'({done, error, programm_run}), 32'd0);
        check_val({name, "_start_ready_addr"}, 32'({byte_ready, ram_addr}), 32'h10);

        for (int i = 0; i < 16; i++) begin
            if (poke_wait && i == 4) begin
                wait_ready(name);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
                check_val({name, "_ign_start_wait"}, 32'({byte_ready, ram_addr}), 32'h14);
            end
            send_byte(sess_bytes[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end

        if (poke_read) begin
            n = 0;
            while (!(ram_rd && ram_addr == 4'd5) && n < 400) begin
                @(negedge clock);
                n++;
            end
            check_val({name, "_rd5_reached"}, 32'(n < 400), 32'd1);
            start = 1'b1;
            repeat (2) @(negedge clock);
            start = 1'b0;
            check_val({name, "_ign_start_read"}, 32'({ram_rd, ram_addr}), 32'h16);
        end

        n = 0;
        while (!(done || error) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check_val({name, "_end_reached"}, 32'(n < 400), 32'd1);
        check_val({name, "_outcome"}, 32'({done, error, programm_run}), 32'(exp_flags));
        for (int i = 0; i < 16; i++)
            check_val($sformatf("%s_mem%0d", name, i), 32'(mem[i]), 32'(sess_bytes[i]));
        check_val({name, "_we_pulses"}, 32'(wr_count), 32'd16);
        check_val({name, "_addr_order"}, 32'(addr_viol), 32'd0);
        check_val({name, "_setup"}, 32'(setup_viol), 32'd0);
        check_val({name, "_hold"}, 32'(hold_viol), 32'd0);

        repeat (6) @(negedge clock);
        check_val({name, "_sticky"}, 32'({done, error, programm_run}), 32'(exp_flags));
        check_val({name, "_no_late_we"}, 32'(wr_count), 32'd16);
        check_val({name, "_exclusive"}, 32'(excl_viol), 32'd0);
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_errors   = 0;
        corrupt_en = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        wr_count   = 0;
        prev_we    = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clock);
        check_val("reset_flags",
                  32'({byte_ready, ram_we, ram_rd, programm_run, done, error}), 32'd0);
        check_val("reset_addr_data", 32'({ram_addr, ram_data}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_val("idle_no_ready", 32'(byte_ready), 32'd0);

        // Full load, back-to-back bytes, with ignored start pokes
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'(8'h10 + i);
        run_session("full", 0, 1'b0, 1'b1, 1'b1);

        // Restart from DONE with all-0xFF image (write sum wraps)
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'hFF;
        run_session("restart_ff", 0, 1'b0, 1'b0, 1'b0);

        // Backpressure with random gaps and random data
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'($urandom_range(255, 0));
        run_session("backpr", 5, 1'b0, 1'b0, 1'b0);

        // Verify failure: RAM returns 0x18 instead of 0x17 at address 7
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'(8'h10 + i);
        run_session("corrupt", 0, 1'b1, 1'b0, 1'b0);

        // Restart from ERROR; error must clear at start
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'($urandom_range(255, 0));
        run_session("after_err", 3, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a write strobe
        pulse_start();
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        n = 0;
        while (!ram_we && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_val("mid_reset_strobe_seen", 32'(ram_we), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("mid_reset_flags",
                  32'({byte_ready, ram_we, ram_rd, programm_run, done, error}), 32'd0);
        check_val("mid_reset_addr_data", 32'({ram_addr, ram_data}), 32'd0);
        byte_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_val("mid_reset_idle", 32'({byte_ready, ram_we, done, error}), 32'd0);

        // Session after reset still works
        for (int i = 0; i < 16; i++) sess_bytes[i] = 8'($urandom_range(255, 0));
        run_session("post_reset", 2, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
